btn_debounce: RTL

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: push-button synchronizer, debouncer and long-press detector.
// Define BTN_LONGPRESS_EN to build the long-press counter and its outputs.
//
// Parameters:
//   DEB_LEN  - stable clk cycles that confirm a press or a release
//   LONG_LEN - clk cycles after press_pulse at which long_pulse fires
// Ports:
//   clk           - system clock, rising edge
//   reset         - synchronous, active-high
//   btn_n         - raw asynchronous button, 0 = pressed
//   btn_level     - debounced level, 1 = pressed
//   press_pulse   - one-cycle pulse on a confirmed press
//   release_pulse - one-cycle pulse on a confirmed release
//   long_pulse    - one-cycle pulse when the long-press time is reached
//   long_active   - high from long_pulse until the confirmed release
module btn_debounce #(
  parameter int DEB_LEN  = 1000000,
  parameter int LONG_LEN = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_active
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // The state-entry cycle counts as the first stable cycle.
  localparam logic [31:0] DEB_LAST = 32'(DEB_LEN - 1);

  logic [1:0]  sync_q;
  logic        s;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        level_d;
  logic        press_d;
  logic        rel_d;

  // Sync flops reset to the released level so a held
  // button is re-debounced after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign s = ~sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = btn_level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

`ifdef BTN_LONGPRESS_EN
  localparam logic [31:0] LONG_TGT  = 32'(LONG_LEN);
  localparam logic [31:0] LONG_LAST = 32'(LONG_LEN - 1);

  logic [31:0] lcnt_q;
  logic [31:0] lcnt_d;
  logic        lpulse_d;
  logic        lact_d;

  // Counts only while PRESSED; holds through release
  // bounce and saturates so long_pulse fires once.
  always_comb begin
    lcnt_d   = lcnt_q;
    lpulse_d = 1'b0;
    lact_d   = long_active;
    if (rel_d) begin
      lcnt_d = '0;
      lact_d = 1'b0;
    end else if (press_d) begin
      lcnt_d = '0;
    end else if (state_q == PRESSED &&
                 lcnt_q != LONG_TGT) begin
      lcnt_d = lcnt_q + 32'd1;
      if (lcnt_q == LONG_LAST) begin
        lpulse_d = 1'b1;
        lact_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_q      <= '0;
      long_pulse  <= 1'b0;
      long_active <= 1'b0;
    end else begin
      lcnt_q      <= lcnt_d;
      long_pulse  <= lpulse_d;
      long_active <= lact_d;
    end
  end
`else
  assign long_pulse  = 1'b0;
  assign long_active = 1'b0;
`endif

endmodule
